wave_ram_loader: RTL and testbench



---
 rtl/wave_ram_loader.sv | 218 +++++++++++++++++++++
 tb/tb_wave_ram_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_ram_loader.sv
// -----------------------------------------------------------------------------
// wave_ram_loader
//
// Writer side of the 3072x32 single-port waveform RAM read by the DDS block.
// Fills one 1024-word segment (00 = triangle, 01 = sine, 10 = square). The
// data comes from an external valid/ready sample stream or from an internal
// triangle/square generator. A one-cycle done pulse marks the end of a fill.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle pulse, begins a fill when idle
//   seg       in   target segment (00 TRI, 01 SIN, 10 SQU, 11 illegal)
//   src_int   in   1 = internal generator, 0 = external stream
//   s_valid   in   external sample valid
//   s_data    in   external sample
//   s_ready   out  loader accepts s_data this cycle
//   ram_wrn   out  RAM write strobe (1 = write)
//   ram_addr  out  RAM address {seg, offset}
//   ram_din   out  RAM write data
//   busy      out  fill in progress
//   done      out  one-cycle pulse after the last word is written
//   err       out  sticky illegal-request flag, cleared by an accepted start
//   checksum  out  (only with WAVE_RAM_LOADER_CHECKSUM_EN) modulo sum of all
//                  words written in the current fill
//
// Optional feature macro: WAVE_RAM_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module wave_ram_loader #(
   parameter int DATA_DEPTH = 3072,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            seg,
   input  logic                  src_int,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic                  ram_wrn,
   output logic [ADDR_WIDTH+1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic                  busy,
   output logic                  done,
   output logic                  err
`ifdef WAVE_RAM_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] checksum
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      FIN  = 2'b10
   } state_t;

   // Three segments share the RAM; the last offset of a segment ends a fill.
   localparam int                    SEG_WORDS = DATA_DEPTH / 3;
   localparam logic [ADDR_WIDTH-1:0] OFF_LAST  = ADDR_WIDTH'(SEG_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] OFF_ONE   = ADDR_WIDTH'(1);
   localparam int                    TRI_SHIFT = DATA_WIDTH - ADDR_WIDTH + 1;

   state_t                  state_q, state_d;
   logic [1:0]              seg_q, seg_d;
   logic                    src_q, src_d;
   logic [ADDR_WIDTH-1:0]   off_q, off_d;
   logic                    last_q, last_d;
   logic                    err_q, err_d;
   logic                    wrn_q, wrn_d;
   logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   din_q, din_d;

   logic legal;
   logic accept;
   logic issue;

   // Triangle: rising ramp over the first half, mirrored over the second half.
   // For the upper half (2**ADDR_WIDTH-1-i) is just the inverted low bits of i.
   // Square: all-ones over the first half, zero over the second.
   function automatic logic [DATA_WIDTH-1:0] gen_word(input logic                  is_squ,
                                                      input logic [ADDR_WIDTH-1:0] i);
      logic [ADDR_WIDTH-2:0] mag;
      mag = i[ADDR_WIDTH-1] ? ~i[ADDR_WIDTH-2:0] : i[ADDR_WIDTH-2:0];
      if (is_squ) begin
         gen_word = i[ADDR_WIDTH-1] ? '0 : '1;
      end else begin
         gen_word = {mag, {TRI_SHIFT{1'b0}}};
      end
   endfunction

   // No internal sine generator exists, so an internal sine request is illegal.
   assign legal  = (seg != 2'b11) && !(src_int && (seg == 2'b01));
   assign accept = (state_q == IDLE) && start && legal;

   // A word is issued in the cycle before it appears on the RAM port. Once the
   // last offset has been issued nothing more is taken.
   assign issue  = (state_q == LOAD) && !last_q && (src_q || s_valid);

   // State register and datapath flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         seg_q   <= 2'b00;
         src_q   <= 1'b0;
         off_q   <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         wrn_q   <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         seg_q   <= seg_d;
         src_q   <= src_d;
         off_q   <= off_d;
         last_q  <= last_d;
         err_q   <= err_d;
         wrn_q   <= wrn_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
      end
   end

   // Next-state logic. last_q is high during the write cycle of the final
   // word, so the FSM leaves LOAD right after that write.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = LOAD;
         LOAD:    if (last_q) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      seg_d  = seg_q;
      src_d  = src_q;
      off_d  = off_q;
      last_d = last_q;
      err_d  = err_q;
      wrn_d  = 1'b0;
      addr_d = addr_q;
      din_d  = din_q;

      if (accept) begin
         seg_d  = seg;
         src_d  = src_int;
         err_d  = 1'b0;
         last_d = 1'b0;
         off_d  = '0;
         // The internal generator never stalls: word 0 is issued on the start
         // edge so the first LOAD cycle is already a write cycle.
         if (src_int) begin
            wrn_d  = 1'b1;
            addr_d = {seg, {ADDR_WIDTH{1'b0}}};
            din_d  = gen_word(seg[1], '0);
            off_d  = OFF_ONE;
         end
      end else if ((state_q == IDLE) && start) begin
         err_d = 1'b1;
      end

      if (issue) begin
         wrn_d  = 1'b1;
         addr_d = {seg_q, off_q};
         din_d  = src_q ? gen_word(seg_q[1], off_q) : s_data;
         // Hold the counter on the last offset so it never spills into the
         // next segment.
         if (off_q == OFF_LAST) begin
            last_d = 1'b1;
         end else begin
            off_d = off_q + OFF_ONE;
         end
      end
   end

   // Outputs
   always_comb begin
      s_ready  = (state_q == LOAD) && !src_q && !last_q;
      busy     = (state_q == LOAD);
      done     = (state_q == FIN);
      err      = err_q;
      ram_wrn  = wrn_q;
      ram_addr = addr_q;
      ram_din  = din_q;
   end

`ifdef WAVE_RAM_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] cks_q, cks_d;

   // Accumulates what actually reaches the RAM port; the final write lands
   // in the cycle before FIN, so the sum is complete when done pulses.
   always_comb begin
      cks_d = cks_q;
      if (accept) begin
         cks_d = '0;
      end else if (wrn_q) begin
         cks_d = cks_q + din_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cks_q <= '0;
      end else begin
         cks_q <= cks_d;
      end
   end

   assign checksum = cks_q;
`endif

endmodule

// File: tb/tb_wave_ram_loader.sv
module tb_wave_ram_loader;

   localparam int DW = 32;
   localparam int AW = 10;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          start   = 1'b0;
   logic [1:0]    seg     = 2'b00;
   logic          src_int = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data  = '0;
   logic          s_ready;
   logic          ram_wrn;
   logic [AW+1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          busy;
   logic          done;
   logic          err;
`ifdef WAVE_RAM_LOADER_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [AW+1:0] addr;
      logic [DW-1:0] data;
      int            cyc;
   } wr_t;

   wr_t sbq[$];

   wave_ram_loader #(
      .DATA_DEPTH(3072),
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .seg      (seg),
      .src_int  (src_int),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_ready  (s_ready),
      .ram_wrn  (ram_wrn),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .busy     (busy),
      .done     (done),
      .err      (err)
`ifdef WAVE_RAM_LOADER_CHECKSUM_EN
      ,
      .checksum (checksum)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference waveform contents
   function automatic logic [DW-1:0] model_word(input logic [1:0] s, input int i);
      if (s == 2'b10) return (i < 512) ? 32'hFFFF_FFFF : 32'h0000_0000;
      if (i < 512) return DW'(i) << 23;
      return DW'(1023 - i) << 23;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0;
      repeat (2) tick();
      tests++; if (ram_wrn !== 1'b0) begin fails++; $display("FAIL reset_ram_wrn: got %b expected 0", ram_wrn); end
      tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
      tests++; if (ram_addr !== '0) begin fails++; $display("FAIL reset_ram_addr: got %h expected 000", ram_addr); end
      tests++; if (ram_din !== '0) begin fails++; $display("FAIL reset_ram_din: got %h expected 00000000", ram_din); end
`ifdef WAVE_RAM_LOADER_CHECKSUM_EN
      tests++; if (checksum !== '0) begin fails++; $display("FAIL reset_checksum: got %h expected 0", checksum); end
`endif
      rst_n = 1'b1;
      repeat (2) tick();
      tests++;
      if ({ram_wrn, busy, done, err, s_ready} !== 5'b0) begin
         fails++; $display("FAIL idle_after_reset: got wrn/busy/done/err/rdy=%b expected 00000", {ram_wrn, busy, done, err, s_ready});
      end
   endtask

   // Internal fill of segment s. poke_at: cycle of a legal start pulse, with an
   // illegal one 5 cycles later (both must be ignored). rst_at: cycle at which
   // reset is asserted mid-fill. Negative values disable either.
   task automatic test_internal_fill(input logic [1:0] s, input int poke_at, input int rst_at);
      int    n_wr    = 0;
      int    n_done  = 0;
      int    done_at = -1;
      wr_t   e;
      string nm;
`ifdef WAVE_RAM_LOADER_CHECKSUM_EN
      logic [DW-1:0] sum = '0;
`endif
      nm = (s == 2'b10) ? "int_squ" : "int_tri";
      sbq.delete();
      for (int i = 0; i < 1024; i++) begin
         e.addr = {s, AW'(i)};
         e.data = model_word(s, i);
         e.cyc  = i + 1;
`ifdef WAVE_RAM_LOADER_CHECKSUM_EN
         sum += e.data;
`endif
         sbq.push_back(e);
      end
      seg = s; src_int = 1'b1; start = 1'b1;
      for (int c = 1; c <= 1200; c++) begin
         tick();
         start = 1'b0;
         if (c == 1) begin
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy_start: got %b expected 1", nm, busy); end
            tests++; if (err !== 1'b0) begin fails++; $display("FAIL %s_err_cleared: got %b expected 0", nm, err); end
            tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL %s_s_ready: got %b expected 0", nm, s_ready); end
         end
         if (ram_wrn === 1'b1) begin
            n_wr++; tests++;
            if (sbq.size() == 0) begin
               fails++; $display("FAIL %s_write: unexpected write addr=%h data=%h at cycle %0d", nm, ram_addr, ram_din, c);
            end else begin
               e = sbq.pop_front();
               if (ram_addr !== e.addr || ram_din !== e.data || c != e.cyc) begin
                  fails++;
                  $display("FAIL %s_write: got addr=%h data=%h cycle=%0d, expected addr=%h data=%h cycle=%0d",
                           nm, ram_addr, ram_din, c, e.addr, e.data, e.cyc);
               end
            end
         end
         if (done === 1'b1) begin
            n_done++; done_at = c;
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_at_done: got %b expected 0", nm, busy); end
`ifdef WAVE_RAM_LOADER_CHECKSUM_EN
            tests++; if (checksum !== sum) begin fails++; $display("FAIL %s_checksum: got %h expected %h", nm, checksum, sum); end
`endif
         end
         if (c == poke_at) begin
            seg = 2'b00; src_int = 1'b1; start = 1'b1;
         end
         if (c == poke_at + 5) begin
            seg = 2'b11; start = 1'b1;
         end
         if (c == poke_at + 6) begin
            seg = s;
            tests++; if (err !== 1'b0) begin fails++; $display("FAIL %s_err_midfill_start: got %b expected 0", nm, err); end
         end
         if (c == rst_at) begin
            rst_n = 1'b0;
            #1;
            tests++; if (ram_wrn !== 1'b0) begin fails++; $display("FAIL %s_async_reset_wrn: got %b expected 0", nm, ram_wrn); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_async_reset_busy: got %b expected 0", nm, busy); end
            sbq.delete();
            repeat (2) tick();
            rst_n = 1'b1;
            for (int j = 0; j < 20; j++) begin
               tick();
               tests++;
               if (done !== 1'b0 || ram_wrn !== 1'b0) begin
                  fails++; $display("FAIL %s_after_reset: got done=%b wrn=%b expected 0 0", nm, done, ram_wrn);
               end
            end
            return;
         end
         if (done_at > 0 && c >= done_at + 3) break;
      end
      tests++; if (n_wr != 1024) begin fails++; $display("FAIL %s_write_count: got %0d expected 1024", nm, n_wr); end
      tests++; if (n_done != 1) begin fails++; $display("FAIL %s_done_count: got %0d expected 1", nm, n_done); end
      tests++; if (done_at != 1025) begin fails++; $display("FAIL %s_done_latency: got %0d expected 1025", nm, done_at); end
      tests++; if (sbq.size() != 0) begin fails++; $display("FAIL %s_missing_writes: got %0d left expected 0", nm, sbq.size()); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_after: got %b expected 0", nm, busy); end
`ifdef WAVE_RAM_LOADER_CHECKSUM_EN
      tests++; if (checksum !== sum) begin fails++; $display("FAIL %s_checksum_hold: got %h expected %h", nm, checksum, sum); end
`endif
   endtask

   task automatic test_ext_sin();
      int            sent      = 0;
      int            n_wr      = 0;
      int            n_done    = 0;
      int            done_at   = -1;
      logic [AW+1:0] last_addr = '0;
      wr_t           e;
      sbq.delete();
      seg = 2'b01; src_int = 1'b0; start = 1'b1; s_valid = 1'b0;
      for (int c = 1; c <= 6000; c++) begin
         tick();
         start = 1'b0;
         if (ram_wrn === 1'b1) begin
            n_wr++; tests++; last_addr = ram_addr;
            if (sbq.size() == 0) begin
               fails++; $display("FAIL ext_write: unexpected write addr=%h data=%h at cycle %0d", ram_addr, ram_din, c);
            end else begin
               e = sbq.pop_front();
               if (ram_addr !== e.addr || ram_din !== e.data || c != e.cyc) begin
                  fails++;
                  $display("FAIL ext_write: got addr=%h data=%h cycle=%0d, expected addr=%h data=%h cycle=%0d",
                           ram_addr, ram_din, c, e.addr, e.data, e.cyc);
               end
            end
         end
         if (done === 1'b1) begin
            n_done++; done_at = c;
         end
         tests++;
         if (s_ready !== (sent < 1024)) begin
            fails++; $display("FAIL ext_s_ready: got %b expected %b at cycle %0d (sent %0d)", s_ready, (sent < 1024), c, sent);
         end
         if (done_at > 0 && c >= done_at + 3) break;
         if (sent < 1024) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = DW'(sent * 3);
         end else begin
            s_valid = 1'b1;
            s_data  = 32'hDEAD_BEEF;
         end
         if (s_valid && s_ready) begin
            e.addr = {2'b01, AW'(sent)};
            e.data = DW'(sent * 3);
            e.cyc  = c + 1;
            sbq.push_back(e);
            sent++;
         end
      end
      s_valid = 1'b0;
      tests++; if (n_wr != 1024) begin fails++; $display("FAIL ext_write_count: got %0d expected 1024", n_wr); end
      tests++; if (n_done != 1) begin fails++; $display("FAIL ext_done_count: got %0d expected 1", n_done); end
      tests++; if (last_addr !== 12'h7FF) begin fails++; $display("FAIL ext_last_addr: got %h expected 7ff", last_addr); end
      tests++; if (sbq.size() != 0) begin fails++; $display("FAIL ext_missing_writes: got %0d left expected 0", sbq.size()); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ext_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_illegal(input logic [1:0] s, input logic si);
      seg = s; src_int = si; start = 1'b1;
      tick();
      start = 1'b0;
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL illegal_err_set seg=%b src=%b: got %b expected 1", s, si, err); end
      for (int j = 0; j < 4; j++) begin
         tests++;
         if (busy !== 1'b0 || ram_wrn !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL illegal_idle seg=%b: got busy=%b wrn=%b done=%b expected 0 0 0", s, busy, ram_wrn, done);
         end
         tick();
      end
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL illegal_err_sticky seg=%b: got %b expected 1", s, err); end
   endtask

   initial begin
      test_reset();
      test_internal_fill(2'b00, -100, -100);
      test_internal_fill(2'b10, -100, -100);
      test_ext_sin();
      test_illegal(2'b11, 1'b0);
      test_internal_fill(2'b00, -100, -100);
      test_illegal(2'b01, 1'b1);
      test_internal_fill(2'b10, -100, -100);
      test_internal_fill(2'b00, -100, 301);
      test_internal_fill(2'b00, -100, -100);
      test_internal_fill(2'b10, 100, -100);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
